// File: rtl/apb_completer_regfile.sv
// apb_completer_regfile: APB completer exposing NUM_REGS byte-writable registers,
// with programmable wait states and PSLVERR on misaligned or out-of-range accesses.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  function automatic int unsigned align_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);
  localparam int unsigned AB = align_bits(DATA_WIDTH);
  localparam int unsigned IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

  apb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic write_q, write_d, err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, prdata_q, prdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0] offset, index;
  logic in_setup, err_live, commit;

  // Outputs are registered, so PREADY/PRDATA/PSLVERR are computed from the next state.
  always_comb begin
    offset = PADDR - BASE_ADDR;
    index = offset >> AB;
    err_live = ((PADDR & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0) || (PADDR < BASE_ADDR)
               || (index >= ADDR_WIDTH'(NUM_REGS));
    in_setup = state_q == SETUP;
    write_d = in_setup ? PWRITE : write_q;
    err_d = in_setup ? err_live : err_q;
    idx_d = in_setup ? IW'(index) : idx_q;
    wdata_d = in_setup ? PWDATA : wdata_q;
    strb_d = in_setup ? PSTRB : strb_q;
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = pready_q ? ((PSEL && !PENABLE) ? SETUP : IDLE) : (PSEL ? ACCESS : IDLE);
      default: state_d = IDLE;
    endcase
    cnt_d = in_setup ? 4'(WAIT_STATES) : (state_d == ACCESS ? cnt_q - 4'd1 : 4'd0);
    pready_d = state_d == ACCESS && cnt_d == 4'd0;
    pslverr_d = pready_d && err_d;
    prdata_d = (pready_d && !write_d && !err_d) ? regs_q[idx_d] : '0;
    commit = state_q == ACCESS && pready_q && write_q && !err_q;
    regs_d = regs_q;
    for (int n = 0; n < STRB_WIDTH; n++)
      if (commit && strb_q[n]) regs_d[idx_q][8*n +: 8] = wdata_q[8*n +: 8];
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_completer_regfile.sv
// tb_apb_completer_regfile: directed bench driving three completers (0, 3 and 2 wait states).
module tb_apb_completer_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] psel = '0;
  logic penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [2:0] pready, pslverr;
  logic [31:0] prdata [3];
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  apb_completer_regfile #(.WAIT_STATES(0)) u0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
  apb_completer_regfile #(.WAIT_STATES(3)) u3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
  apb_completer_regfile #(.WAIT_STATES(2)) u2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic start(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = w;
    paddr = a;
    pwdata = wd;
    pstrb = s;
  endtask

  // n counts ACCESS cycles up to and including the one with PREADY; capped so it never hangs.
  task automatic finish(input int d, input bit keep, output logic [31:0] rd, output logic er,
                        output int n);
    @(posedge clk); #1 penable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1 n++;
    end while (!pready[d] && n < 32);
    rd = prdata[d];
    er = pslverr[d];
    if (!keep) begin
      psel = '0;
      penable = 1'b0;
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output logic er, output int n);
    start(d, w, a, wd, s);
    finish(d, 1'b0, rd, er, n);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic er;
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vecs++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
        errs++;
        $display("FAIL reset_out dut%0d got rdy=%b err=%b data=%h exp 0 0 0", d, pready[d], pslverr[d], prdata[d]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, n);
      vecs++;
      if (rd !== 32'h0 || er !== 1'b0 || n !== 1) begin
        errs++;
        $display("FAIL reset_read reg%0d got data=%h err=%b cyc=%0d exp 0 0 1", i, rd, er, n);
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    logic er;
    int n;
    xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF, rd, er, n);
    vecs++;
    if (er !== 1'b0 || n !== 1) begin
      errs++;
      $display("FAIL lane_write_full got err=%b cyc=%0d exp 0 1", er, n);
    end
    xfer(0, 1'b1, 32'h8, 32'h11223344, 4'h5, rd, er, n);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'hAA22CC44 || er !== 1'b0) begin
      errs++;
      $display("FAIL lane_read got %h err=%b exp AA22CC44 0", rd, er);
    end
    xfer(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, rd, er, n);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, n);
    vecs++;
    if (rd !== 32'hAA22CC44) begin
      errs++;
      $display("FAIL lane_strb0_noop got %h exp AA22CC44", rd);
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd;
    logic er;
    int n;
    xfer(1, 1'b1, 32'h4, 32'h600DCAFE, 4'hF, rd, er, n);
    vecs++;
    if (n !== 4 || er !== 1'b0) begin
      errs++;
      $display("FAIL ws_write got cyc=%0d err=%b exp 4 0", n, er);
    end
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (n !== 4 || rd !== 32'h600DCAFE) begin
      errs++;
      $display("FAIL ws_read got cyc=%0d data=%h exp 4 600DCAFE", n, rd);
    end
    @(posedge clk); #1;
    vecs++;
    if (pready[1] !== 1'b0 || prdata[1] !== 32'h0) begin
      errs++;
      $display("FAIL ws_ready_drop got rdy=%b data=%h exp 0 0", pready[1], prdata[1]);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic er;
    int n;
    xfer(0, 1'b1, 32'h4, 32'h12345678, 4'hF, rd, er, n);
    xfer(0, 1'b1, 32'h3C, 32'h0F0F0F0F, 4'hF, rd, er, n);
    vecs++;
    if (er !== 1'b0) begin
      errs++;
      $display("FAIL err_last_reg got err=%b exp 0", er);
    end
    xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, rd, er, n);
    vecs++;
    if (er !== 1'b1 || n !== 1) begin
      errs++;
      $display("FAIL err_misaligned_wr got err=%b cyc=%0d exp 1 1", er, n);
    end
    xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, rd, er, n);
    vecs++;
    if (er !== 1'b1 || n !== 1) begin
      errs++;
      $display("FAIL err_range_wr got err=%b cyc=%0d exp 1 1", er, n);
    end
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      errs++;
      $display("FAIL err_reg1_kept got %h err=%b exp 12345678 0", rd, er);
    end
    xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h0F0F0F0F || er !== 1'b0) begin
      errs++;
      $display("FAIL err_reg15_kept got %h err=%b exp 0F0F0F0F 0", rd, er);
    end
    xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errs++;
      $display("FAIL err_range_rd got %h err=%b exp 0 1", rd, er);
    end
    xfer(0, 1'b0, 32'h6, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errs++;
      $display("FAIL err_misaligned_rd got %h err=%b exp 0 1", rd, er);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic er;
    int n;
    start(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF);
    finish(0, 1'b1, rd, er, n);
    vecs++;
    if (er !== 1'b0 || n !== 1) begin
      errs++;
      $display("FAIL b2b_write got err=%b cyc=%0d exp 0 1", er, n);
    end
    start(0, 1'b0, 32'h0, 32'h0, 4'h0);
    finish(0, 1'b0, rd, er, n);
    vecs++;
    if (rd !== 32'h5A5A5A5A || er !== 1'b0 || n !== 1) begin
      errs++;
      $display("FAIL b2b_read got %h err=%b cyc=%0d exp 5A5A5A5A 0 1", rd, er, n);
    end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    logic er;
    int n;
    xfer(2, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, er, n);
    vecs++;
    if (n !== 3 || er !== 1'b0) begin
      errs++;
      $display("FAIL abort_setup_write got cyc=%0d err=%b exp 3 0", n, er);
    end
    start(2, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    psel = '0;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (pready[2] !== 1'b0) begin
        errs++;
        $display("FAIL abort_psel_rdy cyc%0d got %b exp 0", i, pready[2]);
      end
    end
    xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'hCAFEF00D || n !== 3) begin
      errs++;
      $display("FAIL abort_psel_kept got %h cyc=%0d exp CAFEF00D 3", rd, n);
    end
    start(2, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 32'h0) begin
      errs++;
      $display("FAIL abort_rst_out got rdy=%b err=%b data=%h exp 0 0 0", pready[2], pslverr[2], prdata[2]);
    end
    rst_n = 1'b1;
    psel = '0;
    penable = 1'b0;
    xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h0 || n !== 3) begin
      errs++;
      $display("FAIL abort_rst_u2 got %h cyc=%0d exp 0 3", rd, n);
    end
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h0) begin
      errs++;
      $display("FAIL abort_rst_u0 got %h exp 0", rd);
    end
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, n);
    vecs++;
    if (rd !== 32'h0 || n !== 4) begin
      errs++;
      $display("FAIL abort_rst_u3 got %h cyc=%0d exp 0 4", rd, n);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
- Parametrised APB completer that exposes a bank of NUM_REGS DATA_WIDTH-bit registers.
- Adds programmable wait states, byte-lane writes via PSTRB, and PSLVERR on misaligned or out-of-range accesses.
- Drives its state machine with the apb_pkg IDLE/SETUP/ACCESS state type; alignment checks use apb_pkg alignment rules.
- Sits behind the APB requester/interconnect as the generic peripheral endpoint.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32.
- STRB_WIDTH, DATA_WIDTH/8, PSTRB width.
- NUM_REGS, 16, register count; 1 to 256.
- WAIT_STATES, 0, extra ACCESS cycles before PREADY; 0 to 15.
- BASE_ADDR, 0, byte address of register 0; must be aligned.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  synchronous reset, active low.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STRB_WIDTH  write byte lanes; PSTRB[n] selects PWDATA[8n+7:8n].
- PREADY  out  1  transfer completes this cycle.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  transfer error.

Behaviour:
- Clock and reset: one clock (PCLK). Reset is synchronous, active-low PRESETn.
- Reset (PRESETn=0 at a PCLK edge): state=IDLE, all registers=0, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0.
- Reset asserted mid-transfer: abort; no register write commits.
- All outputs are registered.
- FSM transitions:
  - IDLE→SETUP when PSEL=1, PENABLE=0.
  - SETUP→ACCESS unconditionally.
  - ACCESS→SETUP after the completing cycle if PSEL=1, PENABLE=0 (back-to-back transfer).
  - ACCESS→IDLE after the completing cycle otherwise.
  - PSEL=0 during ACCESS before completion (protocol violation): →IDLE, no write, PREADY stays 0.
- Sampling: PADDR, PWRITE, PWDATA and PSTRB are captured at the SETUP→ACCESS edge. Later changes in ACCESS are ignored.
- Decode (computed in SETUP):
  - offset = PADDR − BASE_ADDR, modulo 2^ADDR_WIDTH.
  - index = offset >> ALIGNBITS.
  - err = (PADDR[ALIGNBITS-1:0] != 0) or (PADDR < BASE_ADDR) or (index ≥ NUM_REGS).
- Timing: the counter loads WAIT_STATES at the SETUP→ACCESS edge and decrements each ACCESS cycle. PREADY=1 exactly in ACCESS cycle number WAIT_STATES, counting the first ACCESS cycle as 0. With WAIT_STATES=0, PREADY rises in the first ACCESS cycle.
- Completing cycle (PREADY=1):
  - PSLVERR=err. PREADY and PSLVERR are held 0 in all other cycles.
  - Read, no error: PRDATA=reg[index].
  - Read with error: PRDATA=0. PRDATA is 0 outside completing read cycles.
  - Write, no error: at the edge ending the completing cycle, each lane n with PSTRB[n]=1 takes PWDATA lane n; the other lanes keep their value. PSTRB=0 is a legal no-op write.
  - Write with error: no register is modified.
- Reads ignore PSTRB.
- Read after write to the same register in back-to-back transfers returns the new value.
- PREADY deasserts in the cycle after completion. Minimum transfer length is 2 cycles (SETUP + ACCESS).

Test Plan:
- Reset: hold PRESETn=0 for 2 cycles, then read every register → PRDATA=0, PSLVERR=0, PREADY in the first ACCESS cycle.
- Byte-lane write: WAIT_STATES=0; write 0xAABBCCDD to 0x8 with PSTRB=0xF, then 0x11223344 with PSTRB=0x5; read 0x8 → 0xAA22CC44.
- Wait states: WAIT_STATES=3; read 0x4 → PREADY low for 3 ACCESS cycles, high in the 4th; total transfer is 5 cycles.
- Errors: write 0xFFFFFFFF to 0x6 (misaligned) and to 0x40 (index 16, NUM_REGS=16) → PSLVERR=1 with PREADY; reg[1] and reg[15] unchanged; read 0x40 → PRDATA=0, PSLVERR=1.
- Back-to-back: write 0x5A5A5A5A to 0x0, then read 0x0 with no IDLE cycle between → second SETUP taken directly; PRDATA=0x5A5A5A5A.
- Mid-transfer aborts:
  - WAIT_STATES=2; drop PSEL in ACCESS cycle 1 of a write → FSM returns to IDLE, register unchanged.
  - Repeat with PRESETn=0 in ACCESS cycle 1 → all registers 0, outputs 0.
